// File: rtl/store_chk_pkg.sv
// rtl/store_chk_pkg.sv - shared state, fail-code and width definitions for the store sequence checker
package store_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PASS = 2'd2,
      ST_FAIL = 2'd3
   } state_e;

   localparam logic [1:0] FC_NONE    = 2'd0;
   localparam logic [1:0] FC_UNEXP   = 2'd1;
   localparam logic [1:0] FC_DATA    = 2'd2;
   localparam logic [1:0] FC_TIMEOUT = 2'd3;

   localparam int IGN_CNT_W = 16;

endpackage

// File: rtl/store_chk_matcher.sv
// rtl/store_chk_matcher.sv - combinational lookup of one store against the expected and ignore lists
module store_chk_matcher
   import store_chk_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NUM_EXP = 4,
   parameter int NUM_IGN = 4,
   parameter int ORDERED = 1,
   parameter int MC_W    = $clog2(NUM_EXP + 1),
   parameter int IDX_W   = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1
) (
   input  logic [ADDR_W-1:0]         data_adr_i,
   input  logic [DATA_W-1:0]         write_data_i,
   input  logic [NUM_EXP*ADDR_W-1:0] exp_addr_i,
   input  logic [NUM_EXP*DATA_W-1:0] exp_data_i,
   input  logic [NUM_IGN*ADDR_W-1:0] ign_addr_i,
   input  logic [NUM_IGN-1:0]        ign_valid_i,
   input  logic [NUM_EXP-1:0]        hit_mask_i,
   input  logic [MC_W-1:0]           match_count_i,
   output logic                      hit_o,
   output logic [IDX_W-1:0]          hit_idx_o,
   output logic                      data_ok_o,
   output logic                      ignored_o
);

   always_comb begin
      hit_o     = 1'b0;
      hit_idx_o = '0;
      data_ok_o = 1'b0;
      if (ORDERED != 0) begin
         for (int i = 0; i < NUM_EXP; i++) begin
            if (match_count_i == MC_W'(i) && exp_addr_i[i*ADDR_W +: ADDR_W] == data_adr_i) begin
               hit_o     = 1'b1;
               hit_idx_o = IDX_W'(i);
               data_ok_o = (exp_data_i[i*DATA_W +: DATA_W] == write_data_i);
            end
         end
      end else begin
         // Walk downwards so the lowest-index un-hit entry wins.
         for (int i = NUM_EXP - 1; i >= 0; i--) begin
            if (!hit_mask_i[i] && exp_addr_i[i*ADDR_W +: ADDR_W] == data_adr_i) begin
               hit_o     = 1'b1;
               hit_idx_o = IDX_W'(i);
               data_ok_o = (exp_data_i[i*DATA_W +: DATA_W] == write_data_i);
            end
         end
      end
   end

   always_comb begin
      ignored_o = 1'b0;
      for (int j = 0; j < NUM_IGN; j++) begin
         if (ign_valid_i[j] && ign_addr_i[j*ADDR_W +: ADDR_W] == data_adr_i) begin
            ignored_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/store_sequence_checker.sv
// rtl/store_sequence_checker.sv - sticky pass/fail checker of core stores against an expected list
// Optional simulation verdict printout: STORE_CHK_DISPLAY_EN
module store_sequence_checker
   import store_chk_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int NUM_EXP     = 4,
   parameter int NUM_IGN     = 4,
   parameter int ORDERED     = 1,
   parameter int TIMEOUT_CYC = 10000
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           mem_write,
   input  logic [ADDR_W-1:0]              data_adr,
   input  logic [DATA_W-1:0]              write_data,
   input  logic [NUM_EXP*ADDR_W-1:0]      exp_addr,
   input  logic [NUM_EXP*DATA_W-1:0]      exp_data,
   input  logic [NUM_IGN*ADDR_W-1:0]      ign_addr,
   input  logic [NUM_IGN-1:0]             ign_valid,
   output logic                           busy,
   output logic                           done,
   output logic                           pass,
   output logic [1:0]                     fail_code,
   output logic [ADDR_W-1:0]              fail_addr,
   output logic [DATA_W-1:0]              fail_data,
   output logic [$clog2(NUM_EXP+1)-1:0]   match_count,
   output logic [15:0]                    ign_count
);

   localparam int MC_W  = $clog2(NUM_EXP + 1);
   localparam int IDX_W = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1;
   localparam int CYC_W = $clog2(TIMEOUT_CYC);

   state_e                 state_q, state_d;
   logic [NUM_EXP-1:0]     hit_mask_q, hit_mask_d;
   logic [MC_W-1:0]        match_q, match_d;
   logic [IGN_CNT_W-1:0]   ign_q, ign_d;
   logic [CYC_W-1:0]       cyc_q, cyc_d;
   logic [1:0]             fcode_q, fcode_d;
   logic [ADDR_W-1:0]      faddr_q, faddr_d;
   logic [DATA_W-1:0]      fdata_q, fdata_d;

   logic                   m_hit, m_data_ok, m_ignored;
   logic [IDX_W-1:0]       m_hit_idx;

   store_chk_matcher #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .NUM_EXP (NUM_EXP),
      .NUM_IGN (NUM_IGN),
      .ORDERED (ORDERED),
      .MC_W    (MC_W),
      .IDX_W   (IDX_W)
   ) u_matcher (
      .data_adr_i    (data_adr),
      .write_data_i  (write_data),
      .exp_addr_i    (exp_addr),
      .exp_data_i    (exp_data),
      .ign_addr_i    (ign_addr),
      .ign_valid_i   (ign_valid),
      .hit_mask_i    (hit_mask_q),
      .match_count_i (match_q),
      .hit_o         (m_hit),
      .hit_idx_o     (m_hit_idx),
      .data_ok_o     (m_data_ok),
      .ignored_o     (m_ignored)
   );

   always_comb begin
      state_d    = state_q;
      hit_mask_d = hit_mask_q;
      match_d    = match_q;
      ign_d      = ign_q;
      cyc_d      = cyc_q;
      fcode_d    = fcode_q;
      faddr_d    = faddr_q;
      fdata_d    = fdata_q;
      if (state_q == ST_RUN) begin
         if (mem_write) begin
            if (m_hit && m_data_ok) begin
               for (int i = 0; i < NUM_EXP; i++) begin
                  if (m_hit_idx == IDX_W'(i)) hit_mask_d[i] = 1'b1;
               end
               match_d = match_q + 1'b1;
               if (match_q == MC_W'(NUM_EXP - 1)) state_d = ST_PASS;
            end else if (m_hit) begin
               state_d = ST_FAIL;
               fcode_d = FC_DATA;
               faddr_d = data_adr;
               fdata_d = write_data;
            end else if (m_ignored) begin
               if (ign_q != '1) ign_d = ign_q + 1'b1;
            end else begin
               state_d = ST_FAIL;
               fcode_d = FC_UNEXP;
               faddr_d = data_adr;
               fdata_d = write_data;
            end
         end
         // A store that already decided the verdict wins over the timeout.
         if (state_d == ST_RUN) begin
            if (cyc_q == CYC_W'(TIMEOUT_CYC - 1)) begin
               state_d = ST_FAIL;
               fcode_d = FC_TIMEOUT;
               faddr_d = '0;
               fdata_d = '0;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
      end else if (start) begin
         state_d    = ST_RUN;
         hit_mask_d = '0;
         match_d    = '0;
         ign_d      = '0;
         cyc_d      = '0;
         fcode_d    = FC_NONE;
         faddr_d    = '0;
         fdata_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         hit_mask_q <= '0;
         match_q    <= '0;
         ign_q      <= '0;
         cyc_q      <= '0;
         fcode_q    <= FC_NONE;
         faddr_q    <= '0;
         fdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         hit_mask_q <= hit_mask_d;
         match_q    <= match_d;
         ign_q      <= ign_d;
         cyc_q      <= cyc_d;
         fcode_q    <= fcode_d;
         faddr_q    <= faddr_d;
         fdata_q    <= fdata_d;
      end
   end

   assign busy        = (state_q == ST_RUN);
   assign done        = (state_q == ST_PASS) || (state_q == ST_FAIL);
   assign pass        = (state_q == ST_PASS);
   assign fail_code   = fcode_q;
   assign fail_addr   = faddr_q;
   assign fail_data   = fdata_q;
   assign match_count = match_q;
   assign ign_count   = ign_q;

`ifdef STORE_CHK_DISPLAY_EN
   always @(posedge clk) begin
      if (reset && state_q != ST_PASS && state_d == ST_PASS) begin
         $display("Simulation succeeded");
         $stop;
      end
      if (reset && state_q != ST_FAIL && state_d == ST_FAIL) begin
         $display("Simulation failed: fail_code=%0d fail_addr=0x%0h fail_data=0x%0h",
                  fcode_d, faddr_d, fdata_d);
         $stop;
      end
   end
`else
`endif

endmodule

// File: tb/tb_store_sequence_checker.sv
// tb/tb_store_sequence_checker.sv - randomized and directed bench for ordered and unordered checkers
module tb_store_sequence_checker;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NE = 2;
   localparam int NI = 2;
   localparam int TO = 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           reset, start, mem_write;
   logic [AW-1:0]  data_adr;
   logic [DW-1:0]  write_data;
   logic [AW-1:0]  e_addr [NE];
   logic [DW-1:0]  e_data [NE];
   logic [AW-1:0]  i_addr [NI];
   logic [NI-1:0]  ign_valid;
   logic [NE*AW-1:0] exp_addr_p;
   logic [NE*DW-1:0] exp_data_p;
   logic [NI*AW-1:0] ign_addr_p;

   always_comb begin
      exp_addr_p = '0;
      exp_data_p = '0;
      ign_addr_p = '0;
      for (int i = 0; i < NE; i++) begin
         exp_addr_p[i*AW +: AW] = e_addr[i];
         exp_data_p[i*DW +: DW] = e_data[i];
      end
      for (int j = 0; j < NI; j++) ign_addr_p[j*AW +: AW] = i_addr[j];
   end

   // Instance 0 checks in order, instance 1 in any order; both see identical stimulus.
   logic          busy_w [2], done_w [2], pass_w [2];
   logic [1:0]    fc_w [2];
   logic [AW-1:0] fa_w [2];
   logic [DW-1:0] fd_w [2];
   logic [1:0]    mc_w [2];
   logic [15:0]   ic_w [2];

   store_sequence_checker #(.ADDR_W(AW), .DATA_W(DW), .NUM_EXP(NE), .NUM_IGN(NI),
                            .ORDERED(1), .TIMEOUT_CYC(TO)) u_ord (
      .clk(clk), .reset(reset), .start(start), .mem_write(mem_write),
      .data_adr(data_adr), .write_data(write_data),
      .exp_addr(exp_addr_p), .exp_data(exp_data_p), .ign_addr(ign_addr_p), .ign_valid(ign_valid),
      .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .fail_code(fc_w[0]),
      .fail_addr(fa_w[0]), .fail_data(fd_w[0]), .match_count(mc_w[0]), .ign_count(ic_w[0]));

   store_sequence_checker #(.ADDR_W(AW), .DATA_W(DW), .NUM_EXP(NE), .NUM_IGN(NI),
                            .ORDERED(0), .TIMEOUT_CYC(TO)) u_any (
      .clk(clk), .reset(reset), .start(start), .mem_write(mem_write),
      .data_adr(data_adr), .write_data(write_data),
      .exp_addr(exp_addr_p), .exp_data(exp_data_p), .ign_addr(ign_addr_p), .ign_valid(ign_valid),
      .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .fail_code(fc_w[1]),
      .fail_addr(fa_w[1]), .fail_data(fd_w[1]), .match_count(mc_w[1]), .ign_count(ic_w[1]));

   int n_chk  = 0;
   int n_pass = 0;

   bit            pend_we [$];
   logic [AW-1:0] pend_adr [$];
   logic [DW-1:0] pend_dat [$];
   bit            hist_we [$];
   logic [AW-1:0] hist_adr [$];
   logic [DW-1:0] hist_dat [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic push(input bit we, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
      pend_we.push_back(we);
      pend_adr.push_back(adr);
      pend_dat.push_back(dat);
   endtask

   function automatic bit in_ign(input logic [AW-1:0] adr);
      for (int j = 0; j < NI; j++) if (ign_valid[j] && i_addr[j] == adr) return 1'b1;
      return 1'b0;
   endfunction

   // Replays the store history since start. verdict: 0 still running, 1 pass, 2 fail.
   task automatic model(input bit ord, output int verdict, output int code,
                        output logic [AW-1:0] fa, output logic [DW-1:0] fd,
                        output int mc, output int ic);
      bit used [NE];
      verdict = 0; code = 0; fa = '0; fd = '0; mc = 0; ic = 0;
      for (int i = 0; i < NE; i++) used[i] = 1'b0;
      for (int c = 0; c < hist_we.size() && verdict == 0; c++) begin
         if (hist_we[c]) begin
            int idx = -1;
            if (ord) begin
               if (mc < NE && e_addr[mc] == hist_adr[c]) idx = mc;
            end else begin
               for (int i = 0; i < NE; i++)
                  if (idx < 0 && !used[i] && e_addr[i] == hist_adr[c]) idx = i;
            end
            if (idx >= 0 && e_data[idx] == hist_dat[c]) begin
               used[idx] = 1'b1;
               mc++;
               if (mc == NE) verdict = 1;
            end else if (idx >= 0) begin
               verdict = 2; code = 2; fa = hist_adr[c]; fd = hist_dat[c];
            end else if (in_ign(hist_adr[c])) begin
               if (ic < 65535) ic++;
            end else begin
               verdict = 2; code = 1; fa = hist_adr[c]; fd = hist_dat[c];
            end
         end
         if (verdict == 0 && c == TO - 1) begin
            verdict = 2; code = 3; fa = '0; fd = '0;
         end
      end
   endtask

   task automatic begin_seq();
      int guard = 0;
      while ((busy_w[0] || busy_w[1]) && guard < TO + 4) begin
         @(negedge clk);
         guard++;
      end
      if (guard != 0) check("settle_busy", {busy_w[0], busy_w[1]}, 0);
      start = 1'b1;
      mem_write = 1'b0;
      @(negedge clk);
      start = 1'b0;
      hist_we.delete(); hist_adr.delete(); hist_dat.delete();
   endtask

   task automatic drive_and_check(input string tag);
      int v, code, mc, ic;
      logic [AW-1:0] fa;
      logic [DW-1:0] fd;
      while (pend_we.size() > 0) begin
         mem_write  = pend_we[0];
         data_adr   = pend_adr[0];
         write_data = pend_dat[0];
         hist_we.push_back(pend_we.pop_front());
         hist_adr.push_back(pend_adr.pop_front());
         hist_dat.push_back(pend_dat.pop_front());
         @(negedge clk);
      end
      mem_write = 1'b0;
      for (int k = 0; k < 2; k++) begin
         model(k == 0, v, code, fa, fd, mc, ic);
         check($sformatf("%s_u%0d_busy", tag, k), busy_w[k], v == 0);
         check($sformatf("%s_u%0d_done", tag, k), done_w[k], v != 0);
         check($sformatf("%s_u%0d_pass", tag, k), pass_w[k], v == 1);
         check($sformatf("%s_u%0d_code", tag, k), fc_w[k], code);
         check($sformatf("%s_u%0d_faddr", tag, k), fa_w[k], fa);
         check($sformatf("%s_u%0d_fdata", tag, k), fd_w[k], fd);
         check($sformatf("%s_u%0d_mcnt", tag, k), mc_w[k], mc);
         check($sformatf("%s_u%0d_icnt", tag, k), ic_w[k], ic);
      end
   endtask

   task automatic check_zero(input string tag);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s_u%0d_flags", tag, k), {busy_w[k], done_w[k], pass_w[k]}, 0);
         check($sformatf("%s_u%0d_code", tag, k), fc_w[k], 0);
         check($sformatf("%s_u%0d_fa_fd", tag, k), {fa_w[k], fd_w[k]}, 0);
         check($sformatf("%s_u%0d_counts", tag, k), {mc_w[k], ic_w[k]}, 0);
      end
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; mem_write = 1'b0; data_adr = '0; write_data = '0;
      e_addr[0] = 108; e_data[0] = 32'h3FFF_FFFF;
      e_addr[1] = 112; e_data[1] = 32'd7;
      i_addr[0] = 100; i_addr[1] = 104; ign_valid = 2'b11;
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset = 1'b1;
      @(negedge clk);

      begin_seq();
      push(1, 100, 32'd9); push(1, 104, 32'd9); push(1, 108, 32'h3FFF_FFFF);
      drive_and_check("ign_then_hit");
      check("ign_then_hit_icnt_const", ic_w[0], 2);
      push(1, 112, 32'd7);
      drive_and_check("pass_final");
      check("pass_final_const", pass_w[0], 1);

      begin_seq();
      push(1, 108, 32'h3FFF_FFFE);
      drive_and_check("data_mismatch");
      check("data_mismatch_const", {fc_w[0], fa_w[0], fd_w[0]}, {2'd2, 32'd108, 32'h3FFF_FFFE});

      begin_seq();
      push(1, 200, 32'd1);
      drive_and_check("unexpected");
      check("unexpected_const", {fc_w[1], fa_w[1]}, {2'd1, 32'd200});

      e_addr[0] = 32'h10; e_data[0] = 1; e_addr[1] = 32'h14; e_data[1] = 2; ign_valid = 2'b00;
      begin_seq();
      push(1, 32'h14, 2); push(1, 32'h10, 1);
      drive_and_check("order");
      check("order_ord_code", fc_w[0], 1);
      check("order_any_pass", {pass_w[1], mc_w[1]}, {1'b1, 2'd2});

      begin_seq();
      for (int c = 0; c < TO - 1; c++) push(0, 0, 0);
      drive_and_check("timeout_minus1");
      push(0, 0, 0);
      drive_and_check("timeout");
      check("timeout_const", {fc_w[0], fa_w[0]}, {2'd3, 32'd0});

      begin_seq();
      push(1, 32'h10, 1);
      for (int c = 1; c < TO - 1; c++) push(0, 0, 0);
      push(1, 32'h14, 2);
      drive_and_check("hit_on_timeout_edge");
      check("hit_on_timeout_edge_const", pass_w[0], 1);

      begin_seq();
      push(1, 32'h10, 1);
      drive_and_check("pre_abort");
      #2 reset = 1'b0;
      #1 check_zero("async_abort");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      begin_seq();
      drive_and_check("restart");

      for (int s = 0; s < 30; s++) begin
         int n;
         for (int i = 0; i < NE; i++) begin
            e_addr[i] = 32'h10 + 4 * $urandom_range(0, 5);
            e_data[i] = $urandom_range(0, 3);
         end
         for (int j = 0; j < NI; j++) i_addr[j] = 32'h10 + 4 * $urandom_range(0, 5);
         ign_valid = NI'($urandom_range(0, 3));
         begin_seq();
         n = $urandom_range(1, 24);
         for (int c = 0; c < n; c++) begin
            int ei = $urandom_range(0, NE - 1);
            if ($urandom_range(0, 9) < 5)
               push($urandom_range(0, 3) != 0, e_addr[ei],
                    ($urandom_range(0, 4) != 0) ? e_data[ei] : DW'($urandom_range(0, 3)));
            else
               push($urandom_range(0, 3) != 0, 32'h10 + 4 * $urandom_range(0, 5),
                    DW'($urandom_range(0, 3)));
         end
         drive_and_check($sformatf("rand%0d", s));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
